// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings, FSM states and alignment helper for the data-memory unit
package dm_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} dm_state_t;
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/dm_lane.sv
// dm_lane: byte/half/word store merge and load extraction on one 32-bit word
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] cur,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  output logic [31:0] merged,
  output logic [31:0] rdata
);
  logic [31:0] mask, wsh;
  logic [7:0]  b;
  logic [15:0] h;
  assign mask = size == SZ_W ? 32'hFFFF_FFFF : size == SZ_H ? 32'h0000_FFFF << {off[1], 4'b0000} : 32'h0000_00FF << {off, 3'b000};
  assign wsh = size == SZ_W ? wdata : size == SZ_H ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign merged = (cur & ~mask) | (wsh & mask);
  assign b = cur[{off, 3'b000} +: 8];
  assign h = cur[{off[1], 4'b0000} +: 16];
  assign rdata = size == SZ_W ? cur : size == SZ_H ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
endmodule

// File: rtl/dm_unit.sv
// dm_unit: handshaked data memory with wait states, range/alignment checks and power-up clear
module dm_unit
  import dm_pkg::*;
#(
  parameter int DEPTH  = 3072,
  parameter int WAIT   = 0,
  parameter int LOG_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] mem [DEPTH];
  dm_state_t state, nxt;
  logic [AW-1:0] sweep;
  logic [3:0] wcnt;
  logic l_we, l_sgn;
  logic [1:0] l_size;
  logic [31:0] l_addr, l_wdata, l_pc;
  logic [31:0] cur, merged, ext;
  logic err_c, exec;
  assign cur = mem[l_addr[AW+1:2]];
  assign err_c = l_size == 2'b11 || dm_misaligned(l_size, l_addr[1:0]) || l_addr[31:2] >= 30'(DEPTH);
  assign exec = state == S_BUSY && wcnt == 4'd0;
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  dm_lane u_lane (
    .cur(cur),
    .wdata(l_wdata),
    .size(l_size),
    .off(l_addr[1:0]),
    .sgn(l_sgn),
    .merged(merged),
    .rdata(ext)
  );
  // next state: sweep until last word, always pass through BUSY so the access uses latched fields
  always_comb begin
    nxt = state;
    nxt = state == S_INIT ? (sweep == AW'(DEPTH - 1) ? S_IDLE : S_INIT)
        : state == S_IDLE ? (req_valid ? S_BUSY : S_IDLE)
        : state == S_BUSY ? (wcnt == 4'd0 ? S_RESP : S_BUSY)
        : S_IDLE;
  end
  // state, counters, request latch and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      sweep     <= '0;
      wcnt      <= '0;
      l_we      <= 1'b0;
      l_sgn     <= 1'b0;
      l_size    <= '0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_pc      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_INIT) sweep <= sweep + 1'b1;
      if (state == S_IDLE && req_valid) begin
        l_we    <= req_we;
        l_sgn   <= req_signed;
        l_size  <= req_size;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_pc    <= req_pc;
        wcnt    <= 4'(WAIT);
      end
      if (state == S_BUSY && wcnt != 4'd0) wcnt <= wcnt - 1'b1;
      if (exec) begin
        rsp_err   <= err_c;
        rsp_rdata <= (err_c || l_we) ? 32'd0 : ext;
      end
    end
  end
  // array port: clear sweep during INIT, merged store write on a clean access
  always_ff @(posedge clk) begin
    if (state == S_INIT) mem[sweep] <= '0;
    else if (exec && l_we && !err_c) begin
      mem[l_addr[AW+1:2]] <= merged;
      if (LOG_EN != 0) $display("@%h: *%h <= %h", l_pc, {l_addr[31:2], 2'b00}, merged);
    end
  end
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: directed self-checking bench for dm_unit at WAIT=0 and WAIT=3
module tb_dm_unit;
  logic clk = 1'b0;
  logic rst [2];
  logic valid [2];
  logic we [2];
  logic sgn [2];
  logic [1:0] size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] pc [2];
  logic ready [2];
  logic rvalid [2];
  logic [31:0] rdata [2];
  logic err [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_unit #(.DEPTH(16), .WAIT(0), .LOG_EN(1)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_we(we[0]), .req_size(size[0]), .req_signed(sgn[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .req_pc(pc[0]), .rsp_valid(rvalid[0]),
    .rsp_rdata(rdata[0]), .rsp_err(err[0])
  );

  dm_unit #(.DEPTH(16), .WAIT(3), .LOG_EN(1)) u3 (
    .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_we(we[1]), .req_size(size[1]), .req_signed(sgn[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_pc(pc[1]), .rsp_valid(rvalid[1]),
    .rsp_rdata(rdata[1]), .rsp_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input int i, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic busy_ok;
    n = 0;
    while (!ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready[i]), 32'd1);
    valid[i] = 1'b1; we[i] = w; size[i] = sz; sgn[i] = sg;
    addr[i] = a; wdata[i] = d; pc[i] = pc[i] + 32'd4;
    @(posedge clk);
    #1;
    valid[i] = 1'b0; we[i] = ~w; size[i] = 2'b11; sgn[i] = ~sg;
    addr[i] = ~a; wdata[i] = ~d;
    busy_ok = 1'b1;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rvalid[i]) break;
      if (ready[i]) busy_ok = 1'b0;
    end
    lat = n;
    rd = rdata[i];
    er = err[i];
    chk("ready_low_busy", 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rvalid[i]), 32'd0);
    chk("rdata_hold", rdata[i], rd);
  endtask

  task automatic op(input string tag, input int i, input logic w, input logic [1:0] sz,
                    input logic sg, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] erd, input logic eer);
    logic [31:0] rd;
    logic er;
    int lat;
    xact(i, w, sz, sg, a, d, rd, er, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, 32'(er), 32'(eer));
    chk({tag, "_lat"}, 32'(lat), i == 0 ? 32'd2 : 32'd5);
  endtask

  initial begin
    int k;
    logic saw;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; valid[i] = 1'b0; we[i] = 1'b0; sgn[i] = 1'b0; size[i] = 2'b00;
      addr[i] = '0; wdata[i] = '0; pc[i] = 32'h0040_0000;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rvalid[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) chk("ready_before_sweep_end", 32'(ready[0]), 32'd0);
      if (c == 16) chk("ready_after_sweep", 32'(ready[0]), 32'd1);
    end
    op("ld_w_3c", 0, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    op("st_w_10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    op("st_b_11", 0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0);
    op("ld_w_10", 0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h1234_AB78, 1'b0);
    op("ld_bs_11", 0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
    op("ld_bu_11", 0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_00AB, 1'b0);
    op("st_h_22", 0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
    op("ld_hs_22", 0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    op("ld_hu_22", 0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    op("st_h_21", 0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_5555, 32'h0, 1'b1);
    op("ld_w_20", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h8001_0000, 1'b0);
    op("st_w_40", 0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b1);
    op("ld_sz3", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    op("ld_w_12", 0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    op("st_b_13", 0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
    op("ld_bs_13", 0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
    op("ld_hu_12", 0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_8034, 1'b0);
    op("st_h_0", 0, 1'b1, 2'b01, 1'b0, 32'h0, 32'hABCD_7FFF, 32'h0, 1'b0);
    op("ld_hs_0", 0, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0, 32'h0000_7FFF, 1'b0);
    op("w3_st_8", 1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0);
    op("w3_ld_8", 1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hCAFE_F00D, 1'b0);
    op("w3_ld_0", 1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    op("w3_st_3c", 1, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h1111_2222, 32'h0, 1'b0);
    valid[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'h4; wdata[1] = 32'h7777_7777;
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("abort_ready", 32'(ready[1]), 32'd0);
    chk("abort_rsp_valid", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    saw = 1'b0;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rvalid[1]) saw = 1'b1;
      if (ready[1]) begin
        k = c;
        break;
      end
    end
    chk("abort_sweep_restart", 32'(k), 32'd16);
    chk("abort_no_rsp", 32'(saw), 32'd0);
    op("w3_ld_4", 1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
    op("w3_ld_3c", 1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
